// File: rtl/control_unit_if.sv
// Datapath <-> control unit bundle: IR to the sequencer, one-bit strobes back.
// No latency or backpressure of its own; the control unit sets the cadence.
interface control_unit_if;
    logic [31:0] IR;

    logic PCout;
    logic PCin;
    logic IncPC;
    logic MARin;
    logic MDRin;
    logic MDRout;
    logic MDMuxread;
    logic RAMread;
    logic RAMwrite;
    logic IRin;
    logic Yin;
    logic Zlowin;
    logic Zlowout;
    logic CSEout;
    logic Gra;
    logic Grb;
    logic Grc;
    logic Rin;
    logic Rout;
    logic BAout;
    logic ADD;
    logic SUB;
    logic AND;
    logic OR;
    logic Run;

    modport master (
        input  IR,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread,
        output RAMread, RAMwrite, IRin, Yin, Zlowin, Zlowout, CSEout,
        output Gra, Grb, Grc, Rin, Rout, BAout, ADD, SUB, AND, OR, Run
    );

    modport slave (
        output IR,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread,
        input  RAMread, RAMwrite, IRin, Yin, Zlowin, Zlowout, CSEout,
        input  Gra, Grb, Grc, Rin, Rout, BAout, ADD, SUB, AND, OR, Run
    );
endinterface

// File: rtl/control_unit.sv
// Hardwired RST/T0..T7/HALT sequencer; one step per clock, controls are Moore-style from state + opcode.
// No backpressure: fetch is 3 steps, instructions take 4/6/8 cycles, HALT holds until clear is pulled low.
module control_unit (
    input  logic           clock,
    input  logic           clear,
    control_unit_if.master cu
);

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_LD, C_LDI, C_ST, C_ALU, C_ADDI, C_HALT, C_NOP
    } iclass_t;

    typedef struct packed {
        logic pc_out;
        logic pc_in;
        logic inc_pc;
        logic mar_in;
        logic mdr_in;
        logic mdr_out;
        logic md_mux_read;
        logic ram_read;
        logic ram_write;
        logic ir_in;
        logic y_in;
        logic zlow_in;
        logic zlow_out;
        logic cse_out;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic ba_out;
        logic add_sel;
        logic sub_sel;
        logic and_sel;
        logic or_sel;
    } ctrl_t;

    state_t  state;
    state_t  state_nxt;
    iclass_t iclass;
    ctrl_t   ctrl;
    logic    run;
    logic [4:0] opcode;

    assign opcode = cu.IR[31:27];

    // nop shares the "fall back to fetch" class with every undefined opcode
    always_comb begin
        iclass = C_NOP;
        unique case (opcode)
            OP_LD:                          iclass = C_LD;
            OP_LDI:                         iclass = C_LDI;
            OP_ST:                          iclass = C_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR:  iclass = C_ALU;
            OP_ADDI:                        iclass = C_ADDI;
            OP_HALT:                        iclass = C_HALT;
            default:                        iclass = C_NOP;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state <= S_RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ctrl      = '0;
        run       = 1'b1;

        unique case (state)
            S_RST: begin
                state_nxt = S_T0;
            end

            S_T0: begin
                ctrl.pc_out  = 1'b1;
                ctrl.mar_in  = 1'b1;
                ctrl.inc_pc  = 1'b1;
                ctrl.zlow_in = 1'b1;
                state_nxt    = S_T1;
            end

            S_T1: begin
                ctrl.zlow_out    = 1'b1;
                ctrl.pc_in       = 1'b1;
                ctrl.md_mux_read = 1'b1;
                ctrl.ram_read    = 1'b1;
                ctrl.mdr_in      = 1'b1;
                state_nxt        = S_T2;
            end

            S_T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
                state_nxt    = S_T3;
            end

            // memory ops take the base from BA so R0 reads as zero; ALU ops read Rb directly
            S_T3: begin
                unique case (iclass)
                    C_LD, C_LDI, C_ST: begin
                        ctrl.grb    = 1'b1;
                        ctrl.ba_out = 1'b1;
                        ctrl.y_in   = 1'b1;
                        state_nxt   = S_T4;
                    end
                    C_ALU, C_ADDI: begin
                        ctrl.grb   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.y_in  = 1'b1;
                        state_nxt  = S_T4;
                    end
                    C_HALT:  state_nxt = S_HALT;
                    default: state_nxt = S_T0;
                endcase
            end

            S_T4: begin
                state_nxt = S_T5;
                unique case (iclass)
                    C_LD, C_LDI, C_ST, C_ADDI: begin
                        ctrl.cse_out = 1'b1;
                        ctrl.add_sel = 1'b1;
                        ctrl.zlow_in = 1'b1;
                    end
                    C_ALU: begin
                        ctrl.grc     = 1'b1;
                        ctrl.r_out   = 1'b1;
                        ctrl.zlow_in = 1'b1;
                        unique case (opcode)
                            OP_ADD:  ctrl.add_sel = 1'b1;
                            OP_SUB:  ctrl.sub_sel = 1'b1;
                            OP_AND:  ctrl.and_sel = 1'b1;
                            default: ctrl.or_sel  = 1'b1;
                        endcase
                    end
                    default: state_nxt = S_T0;
                endcase
            end

            S_T5: begin
                state_nxt = S_T0;
                unique case (iclass)
                    C_LD, C_ST: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.mar_in   = 1'b1;
                        state_nxt     = S_T6;
                    end
                    C_LDI, C_ALU, C_ADDI: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.gra      = 1'b1;
                        ctrl.r_in     = 1'b1;
                    end
                    default: state_nxt = S_T0;
                endcase
            end

            // st loads MDR from Ra, so the MDR mux stays on the bus side
            S_T6: begin
                state_nxt = S_T0;
                unique case (iclass)
                    C_LD: begin
                        ctrl.md_mux_read = 1'b1;
                        ctrl.ram_read    = 1'b1;
                        ctrl.mdr_in      = 1'b1;
                        state_nxt        = S_T7;
                    end
                    C_ST: begin
                        ctrl.gra    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.mdr_in = 1'b1;
                        state_nxt   = S_T7;
                    end
                    default: state_nxt = S_T0;
                endcase
            end

            S_T7: begin
                state_nxt = S_T0;
                unique case (iclass)
                    C_LD: begin
                        ctrl.mdr_out = 1'b1;
                        ctrl.gra     = 1'b1;
                        ctrl.r_in    = 1'b1;
                    end
                    C_ST:    ctrl.ram_write = 1'b1;
                    default: ctrl.ram_write = 1'b0;
                endcase
            end

            S_HALT: begin
                run       = 1'b0;
                state_nxt = S_HALT;
            end

            default: begin
                state_nxt = S_RST;
            end
        endcase
    end

    assign cu.PCout     = ctrl.pc_out;
    assign cu.PCin      = ctrl.pc_in;
    assign cu.IncPC     = ctrl.inc_pc;
    assign cu.MARin     = ctrl.mar_in;
    assign cu.MDRin     = ctrl.mdr_in;
    assign cu.MDRout    = ctrl.mdr_out;
    assign cu.MDMuxread = ctrl.md_mux_read;
    assign cu.RAMread   = ctrl.ram_read;
    assign cu.RAMwrite  = ctrl.ram_write;
    assign cu.IRin      = ctrl.ir_in;
    assign cu.Yin       = ctrl.y_in;
    assign cu.Zlowin    = ctrl.zlow_in;
    assign cu.Zlowout   = ctrl.zlow_out;
    assign cu.CSEout    = ctrl.cse_out;
    assign cu.Gra       = ctrl.gra;
    assign cu.Grb       = ctrl.grb;
    assign cu.Grc       = ctrl.grc;
    assign cu.Rin       = ctrl.r_in;
    assign cu.Rout      = ctrl.r_out;
    assign cu.BAout     = ctrl.ba_out;
    assign cu.ADD       = ctrl.add_sel;
    assign cu.SUB       = ctrl.sub_sel;
    assign cu.AND       = ctrl.and_sel;
    assign cu.OR        = ctrl.or_sel;
    assign cu.Run       = run;

endmodule

// File: tb/tb_control_unit.sv
// Directed vector table for the fetch/execute/reset sequences, then random instruction
// streams with random resets checked against a per-opcode step-list model.
module tb_control_unit;

    logic clock;
    logic clear;

    control_unit_if cu ();

    control_unit dut (
        .clock (clock),
        .clear (clear),
        .cu    (cu)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // one bit per control output, Run on top
    localparam logic [24:0] PCO   = 25'h1 << 0;
    localparam logic [24:0] PCI   = 25'h1 << 1;
    localparam logic [24:0] INCPC = 25'h1 << 2;
    localparam logic [24:0] MARI  = 25'h1 << 3;
    localparam logic [24:0] MDRI  = 25'h1 << 4;
    localparam logic [24:0] MDRO  = 25'h1 << 5;
    localparam logic [24:0] MDMX  = 25'h1 << 6;
    localparam logic [24:0] RAMR  = 25'h1 << 7;
    localparam logic [24:0] RAMW  = 25'h1 << 8;
    localparam logic [24:0] IRI   = 25'h1 << 9;
    localparam logic [24:0] YI    = 25'h1 << 10;
    localparam logic [24:0] ZLI   = 25'h1 << 11;
    localparam logic [24:0] ZLO   = 25'h1 << 12;
    localparam logic [24:0] CSE   = 25'h1 << 13;
    localparam logic [24:0] GRA   = 25'h1 << 14;
    localparam logic [24:0] GRB   = 25'h1 << 15;
    localparam logic [24:0] GRC   = 25'h1 << 16;
    localparam logic [24:0] RI    = 25'h1 << 17;
    localparam logic [24:0] RO    = 25'h1 << 18;
    localparam logic [24:0] BAO   = 25'h1 << 19;
    localparam logic [24:0] ADDS  = 25'h1 << 20;
    localparam logic [24:0] SUBS  = 25'h1 << 21;
    localparam logic [24:0] ANDS  = 25'h1 << 22;
    localparam logic [24:0] ORS   = 25'h1 << 23;
    localparam logic [24:0] RUN   = 25'h1 << 24;

    localparam logic [24:0] W_RST  = RUN;
    localparam logic [24:0] W_HALT = 25'h0;

    localparam logic [31:0] IR_LD   = 32'h00100038;
    localparam logic [31:0] IR_LDI  = 32'h08800010;
    localparam logic [31:0] IR_ADD  = 32'h1AB38000;
    localparam logic [31:0] IR_ST   = 32'h12180020;
    localparam logic [31:0] IR_UND  = 32'hF8000000;
    localparam logic [31:0] IR_NOP  = 32'hD0000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;

    typedef struct {
        logic        clr;
        logic [31:0] ir;
        logic [24:0] exp;
        string       name;
    } vec_t;

    vec_t vq[$];
    int   n_checks;
    int   n_err;

    function automatic logic [24:0] pack_outputs();
        return {cu.Run, cu.OR, cu.AND, cu.SUB, cu.ADD, cu.BAout, cu.Rout, cu.Rin,
                cu.Grc, cu.Grb, cu.Gra, cu.CSEout, cu.Zlowout, cu.Zlowin, cu.Yin,
                cu.IRin, cu.RAMwrite, cu.RAMread, cu.MDMuxread, cu.MDRout, cu.MDRin,
                cu.MARin, cu.IncPC, cu.PCin, cu.PCout};
    endfunction

    task automatic check(input string name, input logic [24:0] exp);
        logic [24:0] act;
        act = pack_outputs();
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic clr, input logic [31:0] ir, input logic [24:0] exp,
                           input string name);
        vec_t v;
        v.clr  = clr;
        v.ir   = ir;
        v.exp  = exp;
        v.name = name;
        vq.push_back(v);
    endtask

    // drive inputs, check the current step, then take the clock edge
    task automatic step(input logic clr, input logic [31:0] ir, input logic [24:0] exp,
                        input string name);
        clear = clr;
        cu.IR = ir;
        #1;
        check(name, exp);
        @(posedge clock);
        #1;
    endtask

    // Reference: cycle count and per-cycle control word of one instruction, indexed from T0
    function automatic int model_len(input logic [4:0] op);
        case (op)
            5'b00000, 5'b00010:                            return 8;
            5'b00001, 5'b00011, 5'b00100, 5'b00101,
            5'b00110, 5'b01100:                            return 6;
            default:                                       return 4;
        endcase
    endfunction

    function automatic logic [24:0] model_cw(input logic [4:0] op, input int k);
        logic [24:0] fetch [3];
        logic [24:0] tail  [5];
        logic [24:0] alu;
        fetch[0] = PCO | MARI | INCPC | ZLI;
        fetch[1] = ZLO | PCI | MDMX | RAMR | MDRI;
        fetch[2] = MDRO | IRI;
        for (int i = 0; i < 5; i++) tail[i] = '0;
        alu = (op == 5'b00011) ? ADDS : (op == 5'b00100) ? SUBS :
              (op == 5'b00101) ? ANDS : ORS;
        case (op)
            5'b00000: begin
                tail[0] = GRB | BAO | YI;  tail[1] = CSE | ADDS | ZLI;  tail[2] = ZLO | MARI;
                tail[3] = MDMX | RAMR | MDRI;  tail[4] = MDRO | GRA | RI;
            end
            5'b00010: begin
                tail[0] = GRB | BAO | YI;  tail[1] = CSE | ADDS | ZLI;  tail[2] = ZLO | MARI;
                tail[3] = GRA | RO | MDRI;  tail[4] = RAMW;
            end
            5'b00001: begin
                tail[0] = GRB | BAO | YI;  tail[1] = CSE | ADDS | ZLI;  tail[2] = ZLO | GRA | RI;
            end
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                tail[0] = GRB | RO | YI;  tail[1] = GRC | RO | alu | ZLI;  tail[2] = ZLO | GRA | RI;
            end
            5'b01100: begin
                tail[0] = GRB | RO | YI;  tail[1] = CSE | ADDS | ZLI;  tail[2] = ZLO | GRA | RI;
            end
            default: ;
        endcase
        if (op == 5'b11011 && k >= 4) return W_HALT;
        if (k < 3) return RUN | fetch[k];
        if (k - 3 < 5) return RUN | tail[k - 3];
        return RUN;
    endfunction

    initial begin
        logic [4:0]  defined_ops [10];
        logic [4:0]  op;
        logic [31:0] ir;
        logic        aborted;
        int          len;

        n_checks = 0;
        n_err    = 0;
        clear    = 1'b0;
        cu.IR    = 32'h0;

        add_vec(1'b0, 32'h0, W_RST, "rst_hold");
        add_vec(1'b1, 32'h0, W_RST, "rst_release");
        add_vec(1'b1, IR_LD, RUN | PCO | MARI | INCPC | ZLI,      "ld_T0");
        add_vec(1'b1, IR_LD, RUN | ZLO | PCI | MDMX | RAMR | MDRI, "ld_T1");
        add_vec(1'b1, IR_LD, RUN | MDRO | IRI,                    "ld_T2");
        add_vec(1'b1, IR_LD, RUN | GRB | BAO | YI,                "ld_T3");
        add_vec(1'b1, IR_LD, RUN | CSE | ADDS | ZLI,              "ld_T4");
        add_vec(1'b1, IR_LD, RUN | ZLO | MARI,                    "ld_T5");
        add_vec(1'b1, IR_LD, RUN | MDMX | RAMR | MDRI,            "ld_T6");
        add_vec(1'b1, IR_LD, RUN | MDRO | GRA | RI,               "ld_T7");
        add_vec(1'b1, IR_LDI, RUN | PCO | MARI | INCPC | ZLI,      "ldi_T0");
        add_vec(1'b1, IR_LDI, RUN | ZLO | PCI | MDMX | RAMR | MDRI, "ldi_T1");
        add_vec(1'b1, IR_LDI, RUN | MDRO | IRI,                    "ldi_T2");
        add_vec(1'b1, IR_LDI, RUN | GRB | BAO | YI,                "ldi_T3");
        add_vec(1'b1, IR_LDI, RUN | CSE | ADDS | ZLI,              "ldi_T4");
        add_vec(1'b1, IR_LDI, RUN | ZLO | GRA | RI,                "ldi_T5");
        add_vec(1'b1, IR_ADD, RUN | PCO | MARI | INCPC | ZLI,      "add_T0");
        add_vec(1'b1, IR_ADD, RUN | ZLO | PCI | MDMX | RAMR | MDRI, "add_T1");
        add_vec(1'b1, IR_ADD, RUN | MDRO | IRI,                    "add_T2");
        add_vec(1'b1, IR_ADD, RUN | GRB | RO | YI,                 "add_T3");
        add_vec(1'b1, IR_ADD, RUN | GRC | RO | ADDS | ZLI,         "add_T4");
        add_vec(1'b1, IR_ADD, RUN | ZLO | GRA | RI,                "add_T5");
        add_vec(1'b1, IR_ST, RUN | PCO | MARI | INCPC | ZLI,      "st_T0");
        add_vec(1'b1, IR_ST, RUN | ZLO | PCI | MDMX | RAMR | MDRI, "st_T1");
        add_vec(1'b1, IR_ST, RUN | MDRO | IRI,                    "st_T2");
        add_vec(1'b1, IR_ST, RUN | GRB | BAO | YI,                "st_T3");
        add_vec(1'b1, IR_ST, RUN | CSE | ADDS | ZLI,              "st_T4");
        add_vec(1'b1, IR_ST, RUN | ZLO | MARI,                    "st_T5");
        add_vec(1'b1, IR_ST, RUN | GRA | RO | MDRI,               "st_T6");
        add_vec(1'b1, IR_ST, RUN | RAMW,                          "st_T7");
        add_vec(1'b1, IR_UND, RUN | PCO | MARI | INCPC | ZLI,      "und_T0");
        add_vec(1'b1, IR_UND, RUN | ZLO | PCI | MDMX | RAMR | MDRI, "und_T1");
        add_vec(1'b1, IR_UND, RUN | MDRO | IRI,                    "und_T2");
        add_vec(1'b1, IR_UND, RUN,                                 "und_T3");
        add_vec(1'b1, IR_NOP, RUN | PCO | MARI | INCPC | ZLI,      "nop_T0");
        add_vec(1'b1, IR_NOP, RUN | ZLO | PCI | MDMX | RAMR | MDRI, "nop_T1");
        add_vec(1'b1, IR_NOP, RUN | MDRO | IRI,                    "nop_T2");
        add_vec(1'b1, IR_NOP, RUN,                                 "nop_T3");
        add_vec(1'b1, IR_HALT, RUN | PCO | MARI | INCPC | ZLI,      "halt_T0");
        add_vec(1'b1, IR_HALT, RUN | ZLO | PCI | MDMX | RAMR | MDRI, "halt_T1");
        add_vec(1'b1, IR_HALT, RUN | MDRO | IRI,                    "halt_T2");
        add_vec(1'b1, IR_HALT, RUN,                                 "halt_T3");
        add_vec(1'b1, IR_HALT, W_HALT,                              "halt_enter");

        @(posedge clock);
        #1;
        foreach (vq[i]) step(vq[i].clr, vq[i].ir, vq[i].exp, vq[i].name);

        // HALT ignores the opcode and stays put until reset
        for (int i = 0; i < 20; i++) step(1'b1, $urandom, W_HALT, "halt_hold");
        step(1'b0, IR_HALT, W_HALT, "halt_clear_cycle");
        step(1'b1, IR_HALT, W_RST,  "halt_to_rst");

        // reset in the middle of a store must drop the pending write
        for (int k = 0; k < 6; k++) step(1'b1, IR_ST, model_cw(5'b00010, k), "st_pre_rst");
        step(1'b0, IR_ST, model_cw(5'b00010, 6), "st_T6_clear");
        step(1'b1, IR_ST, W_RST, "st_rst_no_write");

        defined_ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                        5'b00101, 5'b00110, 5'b01100, 5'b11010, 5'b11011};
        for (int n = 0; n < 300; n++) begin
            int r;
            r  = $urandom_range(0, 11);
            op = (r < 10) ? defined_ops[r] : 5'($urandom);
            ir = {op, 27'($urandom)};
            len = model_len(op);
            aborted = 1'b0;
            for (int k = 0; k < len; k++) begin
                logic inject;
                inject = ($urandom_range(0, 49) == 0);
                step(!inject, ir, model_cw(op, k), "rand_step");
                if (inject) begin
                    step(1'b1, ir, W_RST, "rand_rst");
                    aborted = 1'b1;
                    break;
                end
            end
            if (op == 5'b11011 && !aborted) begin
                int hold;
                hold = $urandom_range(1, 5);
                for (int h = 0; h < hold; h++) step(1'b1, $urandom, W_HALT, "rand_halt");
                step(1'b0, ir, W_HALT, "rand_halt_clear");
                step(1'b1, ir, W_RST,  "rand_halt_rst");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
